// File: rtl/ws2811_strip_ctrl.sv
// Frame sequencer for a WS2811 strip: reads each pixel word from a synchronous RAM,
// hands it to the bit serializer, then holds the line idle for the latch gap.
module ws2811_strip_ctrl #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned LATCH_CYCLES = 3000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic [23:0]       rgb_data,
  output logic              send,
  input  logic              word_sent,
  output logic [2:0]        db_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_WAIT  = 3'd4,
    S_LATCH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [15:0]       LATCH_LOAD = 16'(LATCH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
  logic [23:0]         rgb_data_q, rgb_data_d;
  logic [15:0]         latch_cnt_q, latch_cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      pix_addr_q  <= '0;
      rgb_data_q  <= '0;
      latch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      pix_addr_q  <= pix_addr_d;
      rgb_data_q  <= rgb_data_d;
      latch_cnt_q <= latch_cnt_d;
    end
  end

  // The address register is updated on entry to FETCH so the RAM sees it during FETCH
  // and its data is ready in LOAD.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    pix_addr_d  = pix_addr_q;
    rgb_data_d  = rgb_data_q;
    latch_cnt_d = latch_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d    = '0;
          pix_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        rgb_data_d = pix_data;
        state_d    = S_SEND;
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (word_sent) begin
          if (index_q == LAST_IDX) begin
            latch_cnt_d = LATCH_LOAD;
            state_d     = S_LATCH;
          end else begin
            index_d    = index_q + 1'b1;
            pix_addr_d = index_q + 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_LATCH: begin
        // Counter runs LATCH_CYCLES-1 down to 0, one state cycle per count.
        if (latch_cnt_q == 16'd0) begin
          state_d = S_DONE;
        end else begin
          latch_cnt_d = latch_cnt_q - 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign send       = (state_q == S_SEND);
  assign pix_addr   = pix_addr_q;
  assign rgb_data   = rgb_data_q;
  assign db_state   = state_q;

endmodule

// File: tb/tb_ws2811_strip_ctrl.sv
// Directed bench: a 3-LED instance with a 10-cycle serializer model and a 1-LED instance,
// both with a 4-cycle latch gap.
module tb_ws2811_strip_ctrl;

  logic        clock = 1'b0;
  logic        reset;

  logic        start_a, word_sent_a, busy_a, frame_done_a, send_a;
  logic [1:0]  pix_addr_a;
  logic [23:0] pix_data_a, rgb_data_a;
  logic [2:0]  db_state_a;

  logic        start_b, word_sent_b, busy_b, frame_done_b, send_b;
  logic [0:0]  pix_addr_b;
  logic [23:0] pix_data_b, rgb_data_b;
  logic [2:0]  db_state_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ws_at    = -100;

  int          send_cyc[$];
  logic [23:0] send_rgb[$];
  int          fetch_cyc[$];
  logic [1:0]  fetch_addr[$];
  int          done_cyc[$];

  logic [23:0] mem_a [4];

  always #5 clock = ~clock;

  ws2811_strip_ctrl #(.NUM_LEDS(3), .ADDR_W(2), .LATCH_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .busy(busy_a),
    .frame_done(frame_done_a), .pix_addr(pix_addr_a), .pix_data(pix_data_a),
    .rgb_data(rgb_data_a), .send(send_a), .word_sent(word_sent_a), .db_state(db_state_a)
  );

  ws2811_strip_ctrl #(.NUM_LEDS(1), .ADDR_W(1), .LATCH_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b),
    .frame_done(frame_done_b), .pix_addr(pix_addr_b), .pix_data(pix_data_b),
    .rgb_data(rgb_data_b), .send(send_b), .word_sent(word_sent_b), .db_state(db_state_b)
  );

  // Synchronous pixel RAMs, one cycle read latency
  always @(posedge clock) pix_data_a <= mem_a[pix_addr_a];
  always @(posedge clock) pix_data_b <= pix_addr_b[0] ? 24'h111111 : 24'hABCDEF;

  // Advance one cycle; log instance A events and drive its serializer model
  task automatic step(input bit extra_ws);
    @(negedge clock);
    cyc++;
    if (db_state_a == 3'd1) begin
      fetch_cyc.push_back(cyc);
      fetch_addr.push_back(pix_addr_a);
    end
    if (send_a === 1'b1) begin
      send_cyc.push_back(cyc);
      send_rgb.push_back(rgb_data_a);
      ws_at = cyc + 10;
      $display("send cyc=%0d rgb=%06h", cyc, rgb_data_a);
    end
    if (frame_done_a === 1'b1) begin
      done_cyc.push_back(cyc);
      $display("frame_done cyc=%0d", cyc);
    end
    word_sent_a = (cyc == ws_at) || extra_ws;
  endtask

  task automatic begin_frame();
    send_cyc.delete(); send_rgb.delete();
    fetch_cyc.delete(); fetch_addr.delete(); done_cyc.delete();
    cyc = 0;
    start_a = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 0; word_sent_a = 0; start_b = 0; word_sent_b = 0;
    repeat (3) step(0);
    reset = 1'b0;
    checks++; if (db_state_a !== 3'd0) begin failures++; $display("FAIL init_state: got %0d expected 0", db_state_a); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL init_busy_b: got %b expected 0", busy_b); end
    begin_frame();
    while (cyc < 20) begin
      step(0);
      start_a = 1'b0;
    end
    checks++; if (db_state_a !== 3'd4) begin failures++; $display("FAIL mid_wait_state: got %0d expected 4", db_state_a); end
    reset = 1'b1;
    repeat (3) step(0);
    reset = 1'b0;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    checks++; if (frame_done_a !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", frame_done_a); end
    checks++; if (send_a !== 1'b0) begin failures++; $display("FAIL rst_send: got %b expected 0", send_a); end
    checks++; if (pix_addr_a !== 2'd0) begin failures++; $display("FAIL rst_pix_addr: got %0d expected 0", pix_addr_a); end
    checks++; if (rgb_data_a !== 24'h0) begin failures++; $display("FAIL rst_rgb: got %06h expected 000000", rgb_data_a); end
    checks++; if (db_state_a !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", db_state_a); end
    // the serializer model still fires word_sent at cycle 26; it must be ignored
    while (cyc < 30) begin
      step(0);
      if (cyc == 27) begin
        checks++; if (db_state_a !== 3'd0) begin failures++; $display("FAIL post_rst_state: got %0d expected 0", db_state_a); end
      end
    end
    checks++; if (send_cyc.size() !== 2) begin failures++; $display("FAIL post_rst_sends: got %0d expected 2", send_cyc.size()); end
  endtask

  task automatic test_single_frame();
    int exp_state;
    int exp_send[3]  = '{3, 16, 29};
    int exp_fetch[3] = '{1, 14, 27};
    logic [23:0] exp_rgb[3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
    begin_frame();
    while (cyc < 46) begin
      step(0);
      start_a = 1'b0;
      case (cyc)
        1: exp_state = 1;  2: exp_state = 2;  3: exp_state = 3;  4: exp_state = 4;
        40: exp_state = 5; 43: exp_state = 5; 44: exp_state = 6; 45: exp_state = 0;
        default: exp_state = -1;
      endcase
      if (exp_state >= 0) begin
        checks++; if (int'(db_state_a) !== exp_state) begin failures++; $display("FAIL frame_state@%0d: got %0d expected %0d", cyc, db_state_a, exp_state); end
      end
      if (cyc == 1) begin
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL busy@1: got %b expected 1", busy_a); end
      end
      if (cyc == 45) begin
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL busy@45: got %b expected 0", busy_a); end
      end
    end
    checks++; if (send_cyc.size() !== 3) begin failures++; $display("FAIL frame_send_count: got %0d expected 3", send_cyc.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (send_cyc[i] !== exp_send[i]) begin failures++; $display("FAIL send_cyc[%0d]: got %0d expected %0d", i, send_cyc[i], exp_send[i]); end
      checks++; if (send_rgb[i] !== exp_rgb[i]) begin failures++; $display("FAIL send_rgb[%0d]: got %06h expected %06h", i, send_rgb[i], exp_rgb[i]); end
      checks++; if (fetch_cyc[i] !== exp_fetch[i]) begin failures++; $display("FAIL fetch_cyc[%0d]: got %0d expected %0d", i, fetch_cyc[i], exp_fetch[i]); end
      checks++; if (fetch_addr[i] !== 2'(i)) begin failures++; $display("FAIL fetch_addr[%0d]: got %0d expected %0d", i, fetch_addr[i], i); end
    end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 44) begin failures++; $display("FAIL frame_done_cyc: got n=%0d first=%0d expected n=1 first=44", done_cyc.size(), done_cyc[0]); end
  endtask

  task automatic test_start_ignored();
    begin_frame();
    while (cyc < 48) begin
      step(0);
      start_a = (cyc == 5) || (cyc == 20);
    end
    checks++; if (send_cyc.size() !== 3) begin failures++; $display("FAIL ign_send_count: got %0d expected 3", send_cyc.size()); end
    checks++; if (fetch_cyc.size() !== 3) begin failures++; $display("FAIL ign_fetch_count: got %0d expected 3", fetch_cyc.size()); end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 44) begin failures++; $display("FAIL ign_done: got n=%0d first=%0d expected n=1 first=44", done_cyc.size(), done_cyc[0]); end
    checks++; if (db_state_a !== 3'd0) begin failures++; $display("FAIL ign_end_state: got %0d expected 0", db_state_a); end
  endtask

  task automatic test_back_to_back();
    begin_frame();
    while (cyc < 95) begin
      step(0);
      start_a = (cyc < 85);
      if (cyc == 45) begin
        checks++; if (db_state_a !== 3'd0) begin failures++; $display("FAIL b2b_gap_state: got %0d expected 0", db_state_a); end
      end
    end
    checks++; if (fetch_cyc.size() !== 6 || fetch_cyc[3] !== 46) begin failures++; $display("FAIL b2b_fetch: got n=%0d second=%0d expected n=6 second=46", fetch_cyc.size(), fetch_cyc[3]); end
    checks++; if (fetch_addr[3] !== 2'd0) begin failures++; $display("FAIL b2b_fetch_addr: got %0d expected 0", fetch_addr[3]); end
    checks++; if (send_cyc.size() !== 6 || send_cyc[3] !== 48) begin failures++; $display("FAIL b2b_send: got n=%0d fourth=%0d expected n=6 fourth=48", send_cyc.size(), send_cyc[3]); end
    checks++; if (done_cyc.size() !== 2 || done_cyc[0] !== 44 || done_cyc[1] !== 89) begin failures++; $display("FAIL b2b_done: got n=%0d %0d,%0d expected n=2 44,89", done_cyc.size(), done_cyc[0], done_cyc[1]); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_end_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_spurious_ws();
    // pix_addr keeps the last fetched address while idle
    checks++; if (pix_addr_a !== 2'd2) begin failures++; $display("FAIL idle_hold_addr: got %0d expected 2", pix_addr_a); end
    step(1);
    step(0);
    checks++; if (db_state_a !== 3'd0 || pix_addr_a !== 2'd2) begin failures++; $display("FAIL spur_idle: got state=%0d addr=%0d expected state=0 addr=2", db_state_a, pix_addr_a); end
    begin_frame();
    step(1);
    start_a = 1'b0;
    while (cyc < 46) begin
      step(cyc == 40);
      if (cyc == 2) begin
        checks++; if (db_state_a !== 3'd2) begin failures++; $display("FAIL spur_fetch_state: got %0d expected 2", db_state_a); end
      end
      if (cyc == 42) begin
        checks++; if (db_state_a !== 3'd5) begin failures++; $display("FAIL spur_latch_state: got %0d expected 5", db_state_a); end
      end
    end
    checks++; if (fetch_cyc.size() !== 3 || fetch_cyc[1] !== 14 || fetch_addr[1] !== 2'd1 || fetch_addr[2] !== 2'd2) begin failures++; $display("FAIL spur_fetch: got n=%0d c1=%0d a1=%0d a2=%0d expected n=3 c1=14 a1=1 a2=2", fetch_cyc.size(), fetch_cyc[1], fetch_addr[1], fetch_addr[2]); end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 44) begin failures++; $display("FAIL spur_done: got n=%0d first=%0d expected n=1 first=44", done_cyc.size(), done_cyc[0]); end
  endtask

  task automatic test_single_led();
    int sends_b = 0;
    int dones_b = 0;
    ws_at = -100;
    cyc = 0;
    start_b = 1'b1;
    while (cyc < 14) begin
      step(0);
      start_b = 1'b0;
      word_sent_b = (cyc == 6);
      if (send_b === 1'b1) begin
        sends_b++;
        $display("send_b cyc=%0d rgb=%06h", cyc, rgb_data_b);
        checks++; if (cyc !== 3 || rgb_data_b !== 24'hABCDEF) begin failures++; $display("FAIL led1_send: got cyc=%0d rgb=%06h expected cyc=3 rgb=abcdef", cyc, rgb_data_b); end
      end
      if (frame_done_b === 1'b1) begin
        dones_b++;
        $display("frame_done_b cyc=%0d", cyc);
        checks++; if (cyc !== 11) begin failures++; $display("FAIL led1_done_cyc: got %0d expected 11", cyc); end
      end
      if (cyc == 1) begin
        checks++; if (db_state_b !== 3'd1 || pix_addr_b !== 1'b0) begin failures++; $display("FAIL led1_fetch: got state=%0d addr=%0d expected state=1 addr=0", db_state_b, pix_addr_b); end
      end
      if (cyc == 7) begin
        checks++; if (db_state_b !== 3'd5) begin failures++; $display("FAIL led1_latch: got %0d expected 5", db_state_b); end
      end
      if (cyc == 12) begin
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL led1_busy@12: got %b expected 0", busy_b); end
      end
    end
    checks++; if (sends_b !== 1) begin failures++; $display("FAIL led1_send_count: got %0d expected 1", sends_b); end
    checks++; if (dones_b !== 1) begin failures++; $display("FAIL led1_done_count: got %0d expected 1", dones_b); end
  endtask

  initial begin
    mem_a[0] = 24'hFF0000;
    mem_a[1] = 24'h00FF00;
    mem_a[2] = 24'h0000FF;
    mem_a[3] = 24'h123456;
    test_reset();
    test_single_frame();
    test_start_ignored();
    test_back_to_back();
    test_spurious_ws();
    test_single_led();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
